// File: rtl/coord_link_pkg.sv
// Types and constants shared by the coordinate link receiver and its byte receiver.
package coord_link_pkg;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hAA;
    localparam logic [7:0] COORD_CENTRE      = 8'd128;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        WAIT_SYNC,
        GET_X,
        GET_Y,
        GET_SUM
    } pkt_state_t;

    function automatic logic [7:0] frame_checksum(input logic [7:0] x, input logic [7:0] y);
        return x ^ y;
    endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver: synchronizes the raw serial pin and recovers one byte per character.
module uart_byte_rx
    import coord_link_pkg::*;
#(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 9600
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx_pin,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    // byte_valid and frame_err are single-cycle strobes with no backpressure:
    // byte_data is meaningful only in the cycle byte_valid is high, and the
    // consumer must take it then. The two strobes are never high together.

    localparam int BAUD_TICK = CLK_FREQ / BAUD_RATE;
    localparam int HALF_TICK = BAUD_TICK / 2;
    localparam int CNT_W     = $clog2(BAUD_TICK + 1);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_TICK - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_TICK - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic             rx_meta;
    logic             rx_sync;
    logic             rx_prev;
    rx_state_t        rx_state;
    logic [CNT_W-1:0] tick_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;

    // rx_prev lets IDLE react only to a 1->0 transition, so a stuck-low line cannot retrigger.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx_pin;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_state   <= IDLE;
            tick_cnt   <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (rx_state)
                IDLE: begin
                    tick_cnt <= '0;
                    if (rx_prev && !rx_sync) begin
                        rx_state <= START;
                    end
                end
                START: begin
                    if (tick_cnt == HALF_LAST) begin
                        tick_cnt <= '0;
                        bit_idx  <= '0;
                        rx_state <= rx_sync ? IDLE : DATA;
                    end else begin
                        tick_cnt <= tick_cnt + CNT_ONE;
                    end
                end
                DATA: begin
                    if (tick_cnt == BIT_LAST) begin
                        tick_cnt <= '0;
                        shift    <= {rx_sync, shift[7:1]};
                        bit_idx  <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            rx_state <= STOP;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + CNT_ONE;
                    end
                end
                STOP: begin
                    if (tick_cnt == BIT_LAST) begin
                        tick_cnt <= '0;
                        rx_state <= IDLE;
                        if (rx_sync) begin
                            byte_valid <= 1'b1;
                            byte_data  <= shift;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + CNT_ONE;
                    end
                end
                default: rx_state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/coord_packet_rx.sv
// Frames received bytes into sync/X/Y/checksum packets and publishes only checksum-clean pairs.
module coord_packet_rx
    import coord_link_pkg::*;
#(
    parameter int         CLK_FREQ      = 50000000,
    parameter int         BAUD_RATE     = 9600,
    parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEFAULT,
    parameter int         TIMEOUT_BAUDS = 30
) (
    input  logic       clk50mhz,
    input  logic       reset_n,
    input  logic       uart_rx,
    output logic [7:0] coord_x,
    output logic [7:0] coord_y,
    output logic       coord_valid,
    output logic       frame_err,
    output logic       csum_err,
    output logic [7:0] err_count
);

    localparam int BAUD_TICK      = CLK_FREQ / BAUD_RATE;
    localparam int TIMEOUT_CYCLES = TIMEOUT_BAUDS * BAUD_TICK;
    localparam int TMO_W          = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

    logic             byte_valid;
    logic [7:0]       byte_data;
    pkt_state_t       pkt_state;
    logic [7:0]       x_stage;
    logic [7:0]       y_stage;
    logic [TMO_W-1:0] tmo_cnt;

    uart_byte_rx #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) u_byte_rx (
        .clk        (clk50mhz),
        .reset_n    (reset_n),
        .rx_pin     (uart_rx),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    // Bytes are positional once sync is seen: a SYNC_BYTE value in X or Y is plain data.
    always_ff @(posedge clk50mhz) begin
        if (!reset_n) begin
            pkt_state   <= WAIT_SYNC;
            x_stage     <= '0;
            y_stage     <= '0;
            tmo_cnt     <= '0;
            coord_x     <= COORD_CENTRE;
            coord_y     <= COORD_CENTRE;
            coord_valid <= 1'b0;
            csum_err    <= 1'b0;
        end else begin
            coord_valid <= 1'b0;
            csum_err    <= 1'b0;
            if (frame_err) begin
                pkt_state <= WAIT_SYNC;
                x_stage   <= '0;
                y_stage   <= '0;
                tmo_cnt   <= '0;
            end else if (byte_valid) begin
                tmo_cnt <= '0;
                case (pkt_state)
                    WAIT_SYNC: begin
                        if (byte_data == SYNC_BYTE) begin
                            pkt_state <= GET_X;
                        end
                    end
                    GET_X: begin
                        x_stage   <= byte_data;
                        pkt_state <= GET_Y;
                    end
                    GET_Y: begin
                        y_stage   <= byte_data;
                        pkt_state <= GET_SUM;
                    end
                    GET_SUM: begin
                        if (byte_data == frame_checksum(x_stage, y_stage)) begin
                            coord_x     <= x_stage;
                            coord_y     <= y_stage;
                            coord_valid <= 1'b1;
                        end else begin
                            csum_err <= 1'b1;
                        end
                        pkt_state <= WAIT_SYNC;
                    end
                    default: pkt_state <= WAIT_SYNC;
                endcase
            end else if (pkt_state != WAIT_SYNC) begin
                // A stalled partial frame is dropped silently; it is not a line error.
                if (tmo_cnt == TMO_LAST) begin
                    tmo_cnt   <= '0;
                    pkt_state <= WAIT_SYNC;
                end else begin
                    tmo_cnt <= tmo_cnt + TMO_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk50mhz) begin
        if (!reset_n) begin
            err_count <= '0;
        end else if ((frame_err || csum_err) && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_coord_packet_rx.sv
// Self-checking bench for coord_packet_rx: serial driver, event-level reference model and scoreboard.
module tb_coord_packet_rx;

    localparam int         CLK_FREQ  = 160000;
    localparam int         BAUD_RATE = 10000;
    localparam int         BT        = CLK_FREQ / BAUD_RATE;
    localparam int         TMO_BAUDS = 30;
    localparam logic [7:0] SYNC      = 8'hAA;
    localparam logic [1:0] EV_COORD  = 2'd1;
    localparam logic [1:0] EV_CSUM   = 2'd2;
    localparam logic [1:0] EV_FRAME  = 2'd3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       uart_rx = 1'b1;
    logic [7:0] coord_x;
    logic [7:0] coord_y;
    logic       coord_valid;
    logic       frame_err;
    logic       csum_err;
    logic [7:0] err_count;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Scoreboard: each entry is {event kind, coord_x, coord_y} as seen on the pulse cycle.
    logic [17:0] exp_q[$];

    // Reference model state: bytes of the frame being assembled, starting with the sync byte.
    logic [7:0] pend[$];
    int         model_err = 0;
    logic [7:0] model_x = 8'd128;
    logic [7:0] model_y = 8'd128;
    int         gap_bits = 0;

    int last_stop_cyc = 0;
    bit chk_latency = 1'b0;

    coord_packet_rx #(
        .CLK_FREQ      (CLK_FREQ),
        .BAUD_RATE     (BAUD_RATE),
        .SYNC_BYTE     (SYNC),
        .TIMEOUT_BAUDS (TMO_BAUDS)
    ) dut (
        .clk50mhz    (clk),
        .reset_n     (reset_n),
        .uart_rx     (uart_rx),
        .coord_x     (coord_x),
        .coord_y     (coord_y),
        .coord_valid (coord_valid),
        .frame_err   (frame_err),
        .csum_err    (csum_err),
        .err_count   (err_count)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #(1200000);
        vectors++;
        miscompares++;
        $display("FAIL watchdog: got no completion, required finish within time limit");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    function automatic int exp_err_count();
        return (model_err > 255) ? 255 : model_err;
    endfunction

    task automatic checkpoint(input string tag);
        check({tag, "_coord_x"}, coord_x, model_x);
        check({tag, "_coord_y"}, coord_y, model_y);
        check({tag, "_err_count"}, err_count, exp_err_count());
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [1:0]  kind;
        logic [17:0] act;
        logic [17:0] exp;
        if (reset_n && (coord_valid || csum_err || frame_err)) begin
            case ({coord_valid, csum_err, frame_err})
                3'b100:  kind = EV_COORD;
                3'b010:  kind = EV_CSUM;
                3'b001:  kind = EV_FRAME;
                default: kind = 2'd0;
            endcase
            act = {kind, coord_x, coord_y};
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_event: got 0x%05h required no event", act);
            end else begin
                exp = exp_q.pop_front();
                check("event", act, exp);
            end
            if (coord_valid && chk_latency) begin
                check("coord_latency_after_stop_start", cyc - last_stop_cyc, 12);
                chk_latency = 1'b0;
            end
        end
    end

    // ---------------- reference model ----------------
    task automatic push_ev(input logic [1:0] kind);
        exp_q.push_back({kind, model_x, model_y});
    endtask

    task automatic model_reset();
        exp_q.delete();
        pend.delete();
        model_err = 0;
        model_x   = 8'd128;
        model_y   = 8'd128;
        gap_bits  = 0;
    endtask

    // Bytes complete every 10 bit periods plus the idle gap; a partial frame dies if that exceeds the timeout.
    task automatic model_byte(input logic [7:0] d, input bit stop_ok);
        if (pend.size() > 0 && (10 + gap_bits) > TMO_BAUDS) pend.delete();
        if (!stop_ok) begin
            pend.delete();
            model_err++;
            push_ev(EV_FRAME);
        end else if (pend.size() == 0) begin
            if (d == SYNC) pend.push_back(d);
        end else if (pend.size() < 3) begin
            pend.push_back(d);
        end else begin
            if (d == (pend[1] ^ pend[2])) begin
                model_x = pend[1];
                model_y = pend[2];
                push_ev(EV_COORD);
            end else begin
                model_err++;
                push_ev(EV_CSUM);
            end
            pend.delete();
        end
        gap_bits = 0;
    endtask

    // ---------------- drivers ----------------
    task automatic drive_bit(input logic b);
        uart_rx = b;
        repeat (BT) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_bit(1'b1);
        gap_bits += n;
    endtask

    task automatic send_byte(input logic [7:0] d, input bit stop_ok);
        model_byte(d, stop_ok);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        last_stop_cyc = cyc;
        drive_bit(stop_ok);
        if (!stop_ok) idle(1);
    endtask

    task automatic send_frame(input logic [7:0] x, input logic [7:0] y, input logic [7:0] s,
                              input int gap_max);
        send_byte(SYNC, 1'b1);
        idle($urandom_range(0, gap_max));
        send_byte(x, 1'b1);
        idle($urandom_range(0, gap_max));
        send_byte(y, 1'b1);
        idle($urandom_range(0, gap_max));
        send_byte(s, 1'b1);
    endtask

    task automatic glitch();
        uart_rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        uart_rx = 1'b1;
    endtask

    task automatic drain(input string tag);
        idle(2);
        check({tag, "_pending_events"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle(1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_coord_x"}, coord_x, 128);
        check({tag, "_coord_y"}, coord_y, 128);
        check({tag, "_coord_valid"}, coord_valid, 0);
        check({tag, "_frame_err"}, frame_err, 0);
        check({tag, "_csum_err"}, csum_err, 0);
        check({tag, "_err_count"}, err_count, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] rx;
        logic [7:0] ry;
        logic [7:0] rs;
        int         kind;

        reset_n = 1'b0;
        uart_rx = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_reset_values("reset");
        reset_n = 1'b1;
        idle(2);

        chk_latency = 1'b1;
        send_frame(8'h3C, 8'hC8, 8'hF4, 0);
        drain("good_frame");
        check("good_frame_latency_seen", chk_latency, 0);
        checkpoint("good_frame");

        do_reset();
        send_frame(8'h10, 8'h20, 8'h31, 0);
        drain("bad_csum");
        checkpoint("bad_csum");
        send_frame(8'h10, 8'h20, 8'h30, 0);
        drain("after_bad_csum");
        checkpoint("after_bad_csum");

        send_byte(8'h55, 1'b1);
        send_byte(8'h00, 1'b1);
        send_frame(8'hAA, 8'h01, 8'hAB, 0);
        drain("sync_as_data");
        checkpoint("sync_as_data");

        send_byte(SYNC, 1'b1);
        send_byte(8'h3C, 1'b0);
        send_byte(8'hC8, 1'b1);
        send_byte(8'hF4, 1'b1);
        drain("frame_err");
        checkpoint("frame_err");

        send_byte(SYNC, 1'b1);
        send_byte(8'h11, 1'b1);
        idle(1);
        glitch();
        idle(1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        drain("glitch");
        checkpoint("glitch");

        send_byte(SYNC, 1'b1);
        send_byte(8'h05, 1'b1);
        idle(31);
        send_byte(8'h06, 1'b1);
        send_byte(8'h03, 1'b1);
        drain("timeout");
        checkpoint("timeout");
        send_frame(8'h07, 8'h08, 8'h0F, 0);
        drain("after_timeout");
        checkpoint("after_timeout");

        send_byte(SYNC, 1'b1);
        send_byte(8'h44, 1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        reset_n = 1'b0;
        model_reset();
        for (int i = 0; i < 5; i++) drive_bit(1'b0);
        drive_bit(1'b1);
        check_reset_values("mid_frame_reset");
        idle(2);
        reset_n = 1'b1;
        gap_bits = 0;
        idle(2);
        send_frame(8'h45, 8'h46, 8'h03, 0);
        drain("after_mid_reset");
        checkpoint("after_mid_reset");

        for (int i = 0; i < 20; i++) begin
            kind = $urandom_range(0, 4);
            rx   = 8'($urandom_range(0, 255));
            ry   = 8'($urandom_range(0, 255));
            case (kind)
                0, 1: send_frame(rx, ry, rx ^ ry, 3);
                2: begin
                    rs = rx ^ ry ^ 8'($urandom_range(1, 255));
                    send_frame(rx, ry, rs, 3);
                end
                3: send_byte(rx, 1'b1);
                default: send_byte(rx, 1'b0);
            endcase
            idle($urandom_range(0, 3));
        end
        drain("random");
        checkpoint("random");

        do_reset();
        for (int i = 0; i < 8; i++) begin
            rx = 8'($urandom_range(0, 255));
            ry = 8'($urandom_range(0, 255));
            send_frame(rx, ry, ~(rx ^ ry), 0);
        end
        drain("sat_csum");
        checkpoint("sat_csum");
        for (int i = 0; i < 252; i++) send_byte(8'h00, 1'b0);
        drain("saturation");
        checkpoint("saturation");
        check("saturation_err_count", err_count, 255);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
